rv32i_rf_wb_arb: RTL
====================

Name: rv32i_rf_wb_arb

Overview:
Write-port arbiter and sequencer for the RV32I register file. It shares the single rd write port between NUM_REQ writeback requesters (index 0 = ALU, 1 = LSU), using round-robin arbitration with valid/ready handshakes. It registers the winning write into reg_sel_rd/reg_rd timing, and exposes a one-cycle forwarding view of the write being committed. It sits between the execute/memory stages and the register file's sys-side signals.

Parameters:
NUM_REQ, 2, number of writeback requesters (>=2)
XLEN, 32, data width
REG_AW, 5, register index width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
req_rd  in  NUM_REQ*REG_AW  per-requester destination index
req_data  in  NUM_REQ*XLEN  per-requester write data
rf_hold  in  1  register file unavailable (e.g. debug access); blocks grants
rf_we  out  1  registered write enable to register file
rf_waddr  out  REG_AW  registered write index
rf_wdata  out  XLEN  registered write data
fwd_vld  out  1  equals rf_we; write in flight this cycle
fwd_addr  out  REG_AW  equals rf_waddr
fwd_data  out  XLEN  equals rf_wdata
commit_cnt  out  32  number of committed non-x0 writes

Behaviour:
- Reset (rst=1 at a clk edge): rf_we=0, rf_waddr=0, rf_wdata=0, commit_cnt=0, last_grant=NUM_REQ-1 (requester 0 wins first), req_ready=0 while rst=1. A pending registered write is discarded; rf_we=0 in the cycle after reset.
- Grant (combinational): search req_valid starting at (last_grant+1) mod NUM_REQ, wrapping. The first valid requester is granted.
- req_ready[i] = grant[i] & ~rf_hold & ~rst. Transfer occurs when req_valid[i] & req_ready[i].
- last_grant updates to i only on a transfer. It holds when no transfer or when rf_hold=1.
- Latency: a transfer in cycle N produces rf_we=1, rf_waddr=req_rd[i], rf_wdata=req_data[i] in cycle N+1 for exactly one cycle.
- x0: a transfer with req_rd=0 is accepted (ready handshake completes) but rf_we stays 0 in N+1. commit_cnt does not increment; waddr/wdata may update.
- No transfer in cycle N (including rf_hold=1) gives rf_we=0 in N+1. rf_waddr/rf_wdata hold their last values.
- Back-to-back: one transfer per cycle max. With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Requester protocol: once req_valid[i]=1, it stays high with stable req_rd/req_data until accepted. The bench asserts this; the RTL relies on it.
- Same-rd collision across requesters: ordering is by grant order. Ordering responsibility lies upstream (hazard unit); no merging occurs here.
- commit_cnt increments by 1 in the cycle rf_we=1 (i.e. registered with the write). It wraps 0xFFFFFFFF -> 0.
- fwd_* mirror rf_* so readers of reg_rs1/reg_rs2 in cycle N+1 can bypass the not-yet-visible write.

Decomposition:
- rv32i_pkg: XLEN, REG_AW, NUM_WB_REQ constants; typedef struct wb_req_t {rd, data}; REG_ZERO constant.
- Sub-module rr_arbiter (parameter N): inputs req, advance, rst, clk; output onehot grant. It holds the last_grant pointer internally. It is reusable for other shared core resources.
- Top contains handshake gating, output register, and counter.

Test Plan:
- Reset, then req_valid=2'b11, rd0=3/data0=0xAAAA0001, rd1=7/data1=0x5555_0002 -> cycle 0 ready=01, cycle1 rf_we=1 waddr=3 wdata=0xAAAA0001, ready=10, cycle2 waddr=7 wdata=0x55550002, commit_cnt=2.
- Both valid continuously for 6 cycles with fresh data per accept -> grant sequence 0,1,0,1,0,1; rf_we high cycles 1-6; commit_cnt=6.
- req_valid=01 rd=0 data=0xDEADBEEF -> ready[0]=1, rf_we=0 next cycle, commit_cnt unchanged.
- rf_hold=1 for 3 cycles with req_valid=10 -> req_ready=00 for those cycles, rf_we=0. Hold releases -> ready=10, write lands the following cycle; last_grant unchanged during hold.
- Transfer in cycle N, rst=1 at cycle N+1 edge -> rf_we=0 after reset, commit_cnt=0, next grant goes to requester 0.
- Preload commit_cnt near 0xFFFFFFFF (force) then 2 non-x0 writes -> wraps to 0x00000000, then 0x00000001.

Source files
------------

// File: rtl/rv32i_rf_wb_arb_pkg.sv
// Shared constants and types for the RV32I register-file writeback path.
// Imported by the writeback arbiter top and its round-robin sub-block.
package rv32i_rf_wb_arb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int NUM_WB_REQ = 2;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rv32i_rf_wb_arb_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant to the first requester after the
// last one that was advanced past; the pointer moves only when advance is set.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic          found;

    // Scan outward from last_q+1 so the most recent winner is considered last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == ((int'(last_q) + off) % N))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    last_d = IW'(i);
                end
            end
        end
    end

    // Reset points at the highest index so requester 0 wins the first round.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rv32i_rf_wb_arb.sv
// Shares the register-file rd write port between the ALU and LSU writeback
// requesters, registering the winning write and mirroring it as a bypass view.
module rv32i_rf_wb_arb #(
    parameter int NUM_REQ = rv32i_rf_wb_arb_pkg::NUM_WB_REQ,
    parameter int XLEN    = rv32i_rf_wb_arb_pkg::XLEN,
    parameter int REG_AW  = rv32i_rf_wb_arb_pkg::REG_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    input  logic                      rf_hold,
    output logic                      rf_we,
    output logic [REG_AW-1:0]         rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    output logic                      fwd_vld,
    output logic [REG_AW-1:0]         fwd_addr,
    output logic [XLEN-1:0]           fwd_data,
    output logic [31:0]               commit_cnt
);

    import rv32i_rf_wb_arb_pkg::*;

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] xfer_vec;
    logic               xfer;
    logic [REG_AW-1:0]  sel_rd;
    logic [XLEN-1:0]    sel_data;

    logic               we_q,     we_d;
    logic [REG_AW-1:0]  waddr_q,  waddr_d;
    logic [XLEN-1:0]    wdata_q,  wdata_d;
    logic [31:0]        commit_cnt_q, commit_cnt_d;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (xfer),
        .grant   (grant)
    );

    assign req_ready = grant & {NUM_REQ{~rf_hold & ~rst}};
    assign xfer_vec  = req_valid & req_ready;
    assign xfer      = |xfer_vec;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer_vec[i]) begin
                sel_rd   = req_rd[i*REG_AW +: REG_AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Writes to x0 complete the handshake but never raise the write enable.
    always_comb begin
        we_d         = xfer && (sel_rd != REG_ZERO);
        waddr_d      = xfer ? sel_rd   : waddr_q;
        wdata_d      = xfer ? sel_data : wdata_q;
        commit_cnt_d = we_d ? (commit_cnt_q + 32'd1) : commit_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            commit_cnt_q <= '0;
        end else begin
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign rf_we      = we_q;
    assign rf_waddr   = waddr_q;
    assign rf_wdata   = wdata_q;
    assign fwd_vld    = we_q;
    assign fwd_addr   = waddr_q;
    assign fwd_data   = wdata_q;
    assign commit_cnt = commit_cnt_q;

endmodule
